// File: rtl/vie_ifc_bridge_if.sv
// Bus bundles for the fetch-side valid/ready channel and the SRAM-like instruction port.
// The fetch stage drives "master" on vie_fetch_if; the bridge drives "master" on vie_inst_if.

interface vie_fetch_if;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        if_resp_ready;

  modport master (
    output if_req_valid, if_req_addr, if_resp_ready,
    input  if_req_ready, if_resp_valid, if_resp_inst
  );
  modport slave (
    input  if_req_valid, if_req_addr, if_resp_ready,
    output if_req_ready, if_resp_valid, if_resp_inst
  );
endinterface

interface vie_inst_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );
  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/vie_ifc_bridge.sv
// Fetch-to-SRAM-like instruction bridge: one outstanding address phase, in-order data,
// credit-limited response FIFO, and flush handling that drops every older in-flight word.

module vie_ifc_bridge #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  vie_fetch_if.slave  fetch_bus,
  vie_inst_if.master  inst_bus
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);

  logic [0:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          pend_q, pend_d;
  logic [31:0]   mem_q [BUF_DEPTH];

  logic          accept, addr_acc, push, pop;
  logic [CW:0]   credit_used;

  // In-flight requests (including ones to be discarded) hold FIFO credit, so data_ok always has room.
  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
  assign fetch_bus.if_req_ready = !reset && (state_q == S_IDLE) && !flush
                                  && (credit_used < {1'b0, DEPTH_C});

  assign accept   = fetch_bus.if_req_valid && fetch_bus.if_req_ready;
  assign addr_acc = (state_q == S_REQ) && inst_bus.inst_addr_ok;
  assign push     = inst_bus.inst_data_ok && (discard_q == '0) && !flush;
  assign pop      = fetch_bus.if_resp_valid && fetch_bus.if_resp_ready && !flush;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    inflight_d = inflight_q + CW'(addr_acc) - CW'(inst_bus.inst_data_ok);
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_REQ;
        addr_d  = fetch_bus.if_req_addr;
      end
      default: if (inst_bus.inst_addr_ok) state_d = S_IDLE;
    endcase

    if (flush) begin
      // Everything still outstanding after this cycle is stale; an address phase
      // still waiting for addr_ok is remembered and discarded once it is accepted.
      discard_d = inflight_d;
      pend_d    = (state_q == S_REQ) && !inst_bus.inst_addr_ok;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      discard_d = discard_q - CW'(inst_bus.inst_data_ok && (discard_q != '0))
                            + CW'(addr_acc && pend_q);
      if (addr_acc) pend_d = 1'b0;
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= inst_bus.inst_rdata;
  end

  assign fetch_bus.if_resp_valid = (count_q != '0);
  assign fetch_bus.if_resp_inst  = (count_q != '0) ? mem_q[rd_ptr_q] : 32'h0;

  assign inst_bus.inst_req   = (state_q == S_REQ);
  assign inst_bus.inst_addr  = addr_q;
  assign inst_bus.inst_wr    = 1'b0;
  assign inst_bus.inst_size  = 2'b10;
  assign inst_bus.inst_wdata = 32'h0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(inst_bus.inst_data_ok && (inflight_q == '0)));
      assert (!(addr_acc && !inst_bus.inst_data_ok && (inflight_q == DEPTH_C)));
      assert (!(push && !pop && (count_q == DEPTH_C)));
      assert (!(!flush && addr_acc && pend_q && (discard_q == DEPTH_C)));
    end
  end

endmodule

// File: tb/tb_vie_ifc_bridge.sv
// Directed bench for vie_ifc_bridge with a queue-based in-order SRAM-like slave model.
// Each scenario task drives stimulus and checks outputs against hand-computed words.

module tb_vie_ifc_bridge;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  initial forever #5 clock = ~clock;

  vie_fetch_if fb();
  vie_inst_if  ib();

  vie_ifc_bridge #(.BUF_DEPTH(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .fetch_bus (fb),
    .inst_bus  (ib)
  );

  int checks = 0;
  int errors = 0;

  // Slave model: addr_ok after addr_ok_delay cycles of inst_req, data one cycle later unless held.
  int          addr_ok_delay = 0;
  logic        data_hold = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] rq [$];
  logic        dok = 1'b0;
  logic [31:0] rdat = 32'h0;

  assign ib.inst_addr_ok = ib.inst_req && (wait_cnt >= addr_ok_delay);
  assign ib.inst_data_ok = dok;
  assign ib.inst_rdata   = rdat;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'hbfc00000) return 32'h3c1a0000;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      rq.delete();
      dok      <= 1'b0;
      rdat     <= 32'h0;
      wait_cnt <= 0;
    end else begin
      if (ib.inst_addr_ok) begin
        rq.push_back(word_of(ib.inst_addr));
        wait_cnt <= 0;
      end else if (ib.inst_req) begin
        wait_cnt <= wait_cnt + 1;
      end
      if (!data_hold && rq.size() > 0) begin
        dok  <= 1'b1;
        rdat <= rq.pop_front();
      end else begin
        dok <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Presents one fetch and returns in the cycle after it is accepted.
  task automatic fetch(input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    fb.if_req_valid = 1'b1;
    fb.if_req_addr  = a;
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      ok = fb.if_req_ready;
      tick();
    end
    fb.if_req_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL fetch_accept addr=%h: got no accept, want accept within 30 cycles", a); end
  endtask

  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fb.if_resp_valid === 1'b1) begin got = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    fb.if_req_valid = 1'b0; fb.if_req_addr = 32'h0; fb.if_resp_ready = 1'b0;
    repeat (3) tick();
    fb.if_req_valid = 1'b1;
    #1;
    checks++; if (ib.inst_req !== 1'b0) begin errors++; $display("FAIL reset_inst_req: got %b want 0", ib.inst_req); end
    checks++; if (ib.inst_addr !== 32'h0) begin errors++; $display("FAIL reset_inst_addr: got %h want 0", ib.inst_addr); end
    checks++; if (fb.if_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", fb.if_resp_valid); end
    checks++; if (fb.if_resp_inst !== 32'h0) begin errors++; $display("FAIL reset_resp_inst: got %h want 0", fb.if_resp_inst); end
    checks++; if (fb.if_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", fb.if_req_ready); end
    checks++; if ({ib.inst_wr, ib.inst_size, ib.inst_wdata} !== {1'b0, 2'b10, 32'h0}) begin
      errors++; $display("FAIL reset_consts: got wr=%b size=%b wdata=%h want 0/10/0", ib.inst_wr, ib.inst_size, ib.inst_wdata);
    end
    fb.if_req_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    fetch(32'hbfc00000);
    checks++; if ({ib.inst_req, ib.inst_addr} !== {1'b1, 32'hbfc00000}) begin
      errors++; $display("FAIL single_req_t1: got req=%b addr=%h want 1/bfc00000", ib.inst_req, ib.inst_addr);
    end
    tick();
    checks++; if ({ib.inst_req, fb.if_resp_valid} !== 2'b00) begin
      errors++; $display("FAIL single_t2: got req=%b resp_valid=%b want 0/0", ib.inst_req, fb.if_resp_valid);
    end
    tick();
    checks++; if ({fb.if_resp_valid, fb.if_resp_inst} !== {1'b1, 32'h3c1a0000}) begin
      errors++; $display("FAIL single_resp_t3: got valid=%b inst=%h want 1/3c1a0000", fb.if_resp_valid, fb.if_resp_inst);
    end
    fb.if_resp_ready = 1'b1;
    tick();
    fb.if_resp_ready = 1'b0;
    checks++; if (fb.if_resp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got valid=%b want 0", fb.if_resp_valid); end
  endtask

  task automatic test_credit();
    fb.if_resp_ready = 1'b0;
    fetch(32'hbfc00000);
    fetch(32'hbfc00004);
    repeat (4) tick();
    fb.if_req_valid = 1'b1; fb.if_req_addr = 32'hbfc00008;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({fb.if_req_ready, ib.inst_req} !== 2'b00) begin
        errors++; $display("FAIL credit_block cyc%0d: got ready=%b req=%b want 0/0", i, fb.if_req_ready, ib.inst_req);
      end
      tick();
    end
    fb.if_req_valid = 1'b0;
    checks++; if ({fb.if_resp_valid, fb.if_resp_inst} !== {1'b1, 32'h3c1a0000}) begin
      errors++; $display("FAIL credit_head0: got valid=%b inst=%h want 1/3c1a0000", fb.if_resp_valid, fb.if_resp_inst);
    end
    fb.if_resp_ready = 1'b1;
    tick();
    checks++; if ({fb.if_resp_valid, fb.if_resp_inst} !== {1'b1, 32'h0004fffb}) begin
      errors++; $display("FAIL credit_head1: got valid=%b inst=%h want 1/0004fffb", fb.if_resp_valid, fb.if_resp_inst);
    end
    tick();
    fb.if_resp_ready = 1'b0;
    #1;
    checks++; if ({fb.if_resp_valid, fb.if_req_ready} !== 2'b01) begin
      errors++; $display("FAIL credit_drained: got valid=%b ready=%b want 0/1", fb.if_resp_valid, fb.if_req_ready);
    end
  endtask

  task automatic test_stall();
    bit got;
    addr_ok_delay = 5;
    fetch(32'hbfc00008);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({ib.inst_req, ib.inst_addr} !== {1'b1, 32'hbfc00008}) begin
        errors++; $display("FAIL stall_hold cyc%0d: got req=%b addr=%h want 1/bfc00008", i, ib.inst_req, ib.inst_addr);
      end
      tick();
    end
    checks++; if (fb.if_resp_valid !== 1'b0) begin errors++; $display("FAIL stall_early_resp: got %b want 0", fb.if_resp_valid); end
    addr_ok_delay = 0;
    wait_resp(got);
    checks++; if ({got, fb.if_resp_inst} !== {1'b1, 32'h0008fff7}) begin
      errors++; $display("FAIL stall_resp: got valid=%b inst=%h want 1/0008fff7", got, fb.if_resp_inst);
    end
    fb.if_resp_ready = 1'b1;
    tick();
    fb.if_resp_ready = 1'b0;
  endtask

  task automatic test_flush_inflight();
    bit got;
    data_hold = 1'b1;
    fb.if_resp_ready = 1'b1;
    fetch(32'hbfc00010);
    fetch(32'hbfc00014);
    tick();
    flush = 1'b1;
    #1;
    checks++; if (fb.if_req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", fb.if_req_ready); end
    tick();
    flush = 1'b0;
    checks++; if (dut.discard_q !== 2'd2) begin errors++; $display("FAIL flush_discard: got %0d want 2", dut.discard_q); end
    data_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (fb.if_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped cyc%0d: got valid=%b want 0", i, fb.if_resp_valid); end
      tick();
    end
    checks++; if ({dut.discard_q, dut.inflight_q} !== 4'h0) begin
      errors++; $display("FAIL flush_counters: got discard=%0d inflight=%0d want 0/0", dut.discard_q, dut.inflight_q);
    end
    fetch(32'hbfc00380);
    wait_resp(got);
    checks++; if ({got, fb.if_resp_inst} !== {1'b1, 32'h0380fc7f}) begin
      errors++; $display("FAIL flush_next: got valid=%b inst=%h want 1/0380fc7f", got, fb.if_resp_inst);
    end
    tick();
    fb.if_resp_ready = 1'b0;
  endtask

  task automatic test_flush_data_pop();
    fb.if_resp_ready = 1'b0;
    fetch(32'hbfc00020);
    repeat (2) tick();
    checks++; if ({fb.if_resp_valid, fb.if_resp_inst} !== {1'b1, 32'h0020ffdf}) begin
      errors++; $display("FAIL fdp_buffered: got valid=%b inst=%h want 1/0020ffdf", fb.if_resp_valid, fb.if_resp_inst);
    end
    data_hold = 1'b1;
    fetch(32'hbfc00024);
    tick();
    data_hold = 1'b0;
    tick();
    flush = 1'b1;
    fb.if_resp_ready = 1'b1;
    tick();
    flush = 1'b0;
    fb.if_resp_ready = 1'b0;
    checks++; if ({fb.if_resp_valid, fb.if_resp_inst} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL fdp_empty: got valid=%b inst=%h want 0/0", fb.if_resp_valid, fb.if_resp_inst);
    end
    checks++; if ({dut.count_q, dut.discard_q, dut.inflight_q} !== 6'h0) begin
      errors++; $display("FAIL fdp_counters: got count=%0d discard=%0d inflight=%0d want 0/0/0", dut.count_q, dut.discard_q, dut.inflight_q);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (fb.if_resp_valid !== 1'b0) begin errors++; $display("FAIL fdp_stale cyc%0d: got valid=%b want 0", i, fb.if_resp_valid); end
    end
  endtask

  task automatic test_flush_pending();
    addr_ok_delay = 3;
    fetch(32'hbfc00030);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({dut.pend_q, dut.discard_q, ib.inst_req, ib.inst_addr} !== {1'b1, 2'd0, 1'b1, 32'hbfc00030}) begin
      errors++; $display("FAIL pend_flag: got pend=%b discard=%0d req=%b addr=%h want 1/0/1/bfc00030",
                         dut.pend_q, dut.discard_q, ib.inst_req, ib.inst_addr);
    end
    repeat (3) tick();
    checks++; if ({dut.pend_q, dut.discard_q, dut.inflight_q} !== {1'b0, 2'd1, 2'd1}) begin
      errors++; $display("FAIL pend_accept: got pend=%b discard=%0d inflight=%0d want 0/1/1", dut.pend_q, dut.discard_q, dut.inflight_q);
    end
    tick();
    checks++; if ({fb.if_resp_valid, dut.discard_q, dut.inflight_q} !== {1'b0, 2'd0, 2'd0}) begin
      errors++; $display("FAIL pend_drop: got valid=%b discard=%0d inflight=%0d want 0/0/0", fb.if_resp_valid, dut.discard_q, dut.inflight_q);
    end
    addr_ok_delay = 0;
  endtask

  task automatic test_reset_mid();
    bit got;
    fb.if_resp_ready = 1'b0;
    fetch(32'hbfc00000);
    repeat (2) tick();
    checks++; if (fb.if_resp_valid !== 1'b1) begin errors++; $display("FAIL rmid_buffered: got %b want 1", fb.if_resp_valid); end
    addr_ok_delay = 4;
    fetch(32'hbfc00004);
    reset = 1'b1;
    tick();
    checks++; if ({ib.inst_req, fb.if_resp_valid, fb.if_resp_inst, fb.if_req_ready} !== 35'h0) begin
      errors++; $display("FAIL rmid_outputs: got req=%b valid=%b inst=%h ready=%b want 0/0/0/0",
                         ib.inst_req, fb.if_resp_valid, fb.if_resp_inst, fb.if_req_ready);
    end
    checks++; if ({dut.count_q, dut.discard_q, dut.inflight_q, dut.pend_q} !== 7'h0) begin
      errors++; $display("FAIL rmid_counters: got count=%0d discard=%0d inflight=%0d pend=%b want 0",
                         dut.count_q, dut.discard_q, dut.inflight_q, dut.pend_q);
    end
    reset = 1'b0;
    addr_ok_delay = 0;
    tick();
    fetch(32'hbfc00380);
    wait_resp(got);
    checks++; if ({got, fb.if_resp_inst} !== {1'b1, 32'h0380fc7f}) begin
      errors++; $display("FAIL rmid_recover: got valid=%b inst=%h want 1/0380fc7f", got, fb.if_resp_inst);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit();
    test_stall();
    test_flush_inflight();
    test_flush_data_pop();
    test_flush_pending();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
